// File: rtl/pe_butterfly.sv
// pe_butterfly: pipelined NTT/INTT butterfly for the processing element.
//
// Performs one Cooley-Tukey (mode_i=0) or Gentleman-Sande (mode_i=1)
// butterfly per cycle over one of two moduli (select_i=0: Q_D, 1: Q_K).
//   CT: y0 = a + b*w,      y1 = a - b*w        (mod q)
//   GS: y0 = a + b,        y1 = (a - b) * w    (mod q)
//
// Register ranks (all advance together on the global adv):
//   s1  : operand capture (a, b, w, select, mode, tag)
//   s2  : CT -> a and p = b*w ; GS -> s = a+b, d = a-b, w
//   s3  : butterfly results
//   out : output register driving y0_o/y1_o/tag_o
// An op accepted at edge n is presented on valid_o after edge n+3.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   valid_i / ready_o  input handshake (ready_o = ~valid_o | ready_i)
//   a_i, b_i, w_i      coefficients and twiddle, expected < q
//   select_i, mode_i   modulus select, butterfly type (travel with the op)
//   tag_i / tag_o      sideband tag (write-back address)
//   valid_o / ready_i  output handshake
//   y0_o, y1_o         butterfly outputs

// Modular multiplier: y = a*b mod q, q chosen by select_i.
module mod_mul #(
    parameter int          W   = 23,
    parameter int unsigned Q_D = 8380417,
    parameter int unsigned Q_K = 3329
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         select_i,
    output logic [W-1:0] y_o
);
    localparam logic [2*W-1:0] QD_X = (2*W)'(Q_D);
    localparam logic [2*W-1:0] QK_X = (2*W)'(Q_K);

    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
    // Both reductions use a constant divisor; the mux picks afterwards.
    assign y_o  = select_i ? W'(prod % QK_X) : W'(prod % QD_X);
endmodule

module pe_butterfly #(
    parameter int          W     = 23,
    parameter int          TAG_W = 8,
    parameter int unsigned Q_D   = 8380417,
    parameter int unsigned Q_K   = 3329
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [W-1:0]     w_i,
    input  logic             select_i,
    input  logic             mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [W-1:0]     y0_o,
    output logic [W-1:0]     y1_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam logic [W-1:0] QD_W = W'(Q_D);
    localparam logic [W-1:0] QK_W = W'(Q_K);

    // (a + b) mod q via a W+1-bit sum and one conditional subtract.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic [W-1:0] q);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, q})
            s = s - {1'b0, q};
        return s[W-1:0];
    endfunction

    // (a - b) mod q: the borrow bit of the W+1-bit difference flags negative.
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic [W-1:0] q);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[W])
            d = d + {1'b0, q};
        return d[W-1:0];
    endfunction

    // Global stall: every rank moves only when the output is free or consumed.
    logic adv;
    assign adv     = ~valid_o | ready_i;
    assign ready_o = adv;

    // Stage 1 registers
    logic             s1_valid_reg, s1_sel_reg, s1_mode_reg;
    logic [W-1:0]     s1_a_reg, s1_b_reg, s1_w_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    // Stage 2 registers: x = a (CT) or s (GS); z = p (CT) or d (GS)
    logic             s2_valid_reg, s2_sel_reg, s2_mode_reg;
    logic [W-1:0]     s2_x_reg, s2_z_reg, s2_w_reg;
    logic [TAG_W-1:0] s2_tag_reg;
    logic [W-1:0]     s2_x_next, s2_z_next;

    // Stage 3 registers
    logic             s3_valid_reg;
    logic [W-1:0]     s3_y0_reg, s3_y1_reg;
    logic [TAG_W-1:0] s3_tag_reg;
    logic [W-1:0]     s3_y0_next, s3_y1_next;

    // Multiplier 0 serves CT in stage 2 (b*w), multiplier 1 serves GS in
    // stage 3 (d*w).
    logic [W-1:0] mm_a   [2];
    logic [W-1:0] mm_b   [2];
    logic         mm_sel [2];
    logic [W-1:0] mm_y   [2];

    assign mm_a[0]   = s1_b_reg;
    assign mm_b[0]   = s1_w_reg;
    assign mm_sel[0] = s1_sel_reg;
    assign mm_a[1]   = s2_z_reg;
    assign mm_b[1]   = s2_w_reg;
    assign mm_sel[1] = s2_sel_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_mm
        mod_mul #(.W(W), .Q_D(Q_D), .Q_K(Q_K)) u_mod_mul (
            .a_i      (mm_a[gi]),
            .b_i      (mm_b[gi]),
            .select_i (mm_sel[gi]),
            .y_o      (mm_y[gi])
        );
    end

    always_comb begin
        s2_x_next = s1_a_reg;
        s2_z_next = mm_y[0];
        if (s1_mode_reg) begin
            s2_x_next = mod_add(s1_a_reg, s1_b_reg, s1_sel_reg ? QK_W : QD_W);
            s2_z_next = mod_sub(s1_a_reg, s1_b_reg, s1_sel_reg ? QK_W : QD_W);
        end
    end

    always_comb begin
        s3_y0_next = mod_add(s2_x_reg, s2_z_reg, s2_sel_reg ? QK_W : QD_W);
        s3_y1_next = mod_sub(s2_x_reg, s2_z_reg, s2_sel_reg ? QK_W : QD_W);
        if (s2_mode_reg) begin
            s3_y0_next = s2_x_reg;
            s3_y1_next = mm_y[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
            s1_sel_reg   <= 1'b0;
            s1_mode_reg  <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_w_reg     <= '0;
            s1_tag_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_sel_reg   <= 1'b0;
            s2_mode_reg  <= 1'b0;
            s2_x_reg     <= '0;
            s2_z_reg     <= '0;
            s2_w_reg     <= '0;
            s2_tag_reg   <= '0;
            s3_valid_reg <= 1'b0;
            s3_y0_reg    <= '0;
            s3_y1_reg    <= '0;
            s3_tag_reg   <= '0;
            valid_o      <= 1'b0;
            y0_o         <= '0;
            y1_o         <= '0;
            tag_o        <= '0;
        end else if (adv) begin
            // Accept happens exactly when valid_i & adv, so valid_i is the
            // stage-1 valid; bubbles ride through with whatever data.
            s1_valid_reg <= valid_i;
            s1_sel_reg   <= select_i;
            s1_mode_reg  <= mode_i;
            s1_a_reg     <= a_i;
            s1_b_reg     <= b_i;
            s1_w_reg     <= w_i;
            s1_tag_reg   <= tag_i;

            s2_valid_reg <= s1_valid_reg;
            s2_sel_reg   <= s1_sel_reg;
            s2_mode_reg  <= s1_mode_reg;
            s2_x_reg     <= s2_x_next;
            s2_z_reg     <= s2_z_next;
            s2_w_reg     <= s1_w_reg;
            s2_tag_reg   <= s1_tag_reg;

            s3_valid_reg <= s2_valid_reg;
            s3_y0_reg    <= s3_y0_next;
            s3_y1_reg    <= s3_y1_next;
            s3_tag_reg   <= s2_tag_reg;

            valid_o      <= s3_valid_reg;
            y0_o         <= s3_y0_reg;
            y1_o         <= s3_y1_reg;
            tag_o        <= s3_tag_reg;
        end
    end
endmodule

// File: tb/tb_pe_butterfly.sv
// Self-checking bench for pe_butterfly: directed vector table, streaming,
// backpressure and mid-flight reset sequences.
module tb_pe_butterfly;
    localparam int    W     = 23;
    localparam int    TAG_W = 8;
    localparam longint QD   = 8380417;
    localparam longint QK   = 3329;

    logic             clk_i = 1'b0;
    logic             rst_i, valid_i, ready_o, select_i, mode_i;
    logic             valid_o, ready_i;
    logic [W-1:0]     a_i, b_i, w_i, y0_o, y1_o;
    logic [TAG_W-1:0] tag_i, tag_o;

    int n_cmp = 0;
    int n_err = 0;

    pe_butterfly #(.W(W), .TAG_W(TAG_W), .Q_D(8380417), .Q_K(3329)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .w_i      (w_i),
        .select_i (select_i),
        .mode_i   (mode_i),
        .tag_i    (tag_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .y0_o     (y0_o),
        .y1_o     (y1_o),
        .tag_o    (tag_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic   mode;
        logic   sel;
        longint a, b, w;
        logic [TAG_W-1:0] tag;
        longint y0, y1;
    } vec_t;

    typedef struct {
        longint y0, y1;
        logic [TAG_W-1:0] tag;
    } exp_t;

    vec_t vecs [10];
    exp_t sb [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference butterfly computed directly from the defining formulas.
    function automatic void model(input logic mode, input logic sel,
                                  input longint a, input longint b, input longint w,
                                  output longint y0, output longint y1);
        longint q, p, d;
        q = sel ? QK : QD;
        if (!mode) begin
            p  = (b * w) % q;
            y0 = (a + p) % q;
            y1 = (a - p + q) % q;
        end else begin
            y0 = (a + b) % q;
            d  = (a - b + q) % q;
            y1 = (d * w) % q;
        end
    endfunction

    // Deterministic stream operand k; operands reduced to the selected modulus.
    function automatic vec_t make_op(input int k);
        vec_t   v;
        longint q;
        v.sel  = k[0];
        v.mode = k[1];
        q      = v.sel ? QK : QD;
        v.a    = (longint'(k) * 7919 + 13) % q;
        v.b    = (longint'(k) * 104729 + 5) % q;
        v.w    = (longint'(k) * 31337 + 1) % q;
        v.tag  = TAG_W'(k + 8'h40);
        model(v.mode, v.sel, v.a, v.b, v.w, v.y0, v.y1);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        mode_i   = v.mode;
        select_i = v.sel;
        a_i      = W'(v.a);
        b_i      = W'(v.b);
        w_i      = W'(v.w);
        tag_i    = v.tag;
    endtask

    // One isolated op: check latency 3 and the result values.
    task automatic single(input vec_t v, input string name);
        int lat;
        bit found;
        @(posedge clk_i); #1;
        drive(v);
        valid_i = 1'b1;
        @(negedge clk_i);
        check({name, "_ready_o"}, longint'(ready_o), 1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 10) begin
            @(posedge clk_i); #1;
            lat++;
            if (valid_o) found = 1'b1;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_y0"}, longint'(y0_o), v.y0);
        check({name, "_y1"}, longint'(y1_o), v.y1);
        check({name, "_tag"}, longint'(tag_o), longint'(v.tag));
        $display("op %s: mode=%0d sel=%0d a=%0d b=%0d w=%0d -> y0=%0d y1=%0d tag=%0h",
                 name, v.mode, v.sel, v.a, v.b, v.w, y0_o, y1_o, tag_o);
    endtask

    // Stream n_ops ops back to back; ready_i low for posedge counts in
    // [stall_start, stall_start+stall_len).
    task automatic run_stream(input int n_ops, input int base, input int stall_start,
                              input int stall_len, output int max_run);
        int   idx, consumed, run, cyc;
        bit   holding;
        logic [W-1:0] h0, h1;
        logic [TAG_W-1:0] ht;
        vec_t v;
        exp_t e;
        idx = 0; consumed = 0; run = 0; cyc = 0; holding = 1'b0; max_run = 0;
        h0 = '0; h1 = '0; ht = '0;
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        drive(make_op(base));
        valid_i = 1'b1;
        while (consumed < n_ops && cyc < 300) begin
            @(negedge clk_i);
            if (valid_o) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (valid_o && !ready_i) begin
                check("stall_ready_o", longint'(ready_o), 0);
                if (holding) begin
                    check("stall_y0_hold", longint'(y0_o), longint'(h0));
                    check("stall_y1_hold", longint'(y1_o), longint'(h1));
                    check("stall_tag_hold", longint'(tag_o), longint'(ht));
                end
                holding = 1'b1;
                h0 = y0_o; h1 = y1_o; ht = tag_o;
            end else begin
                holding = 1'b0;
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stream_extra: got tag %0h, expected no result", tag_o);
                end else begin
                    e = sb.pop_front();
                    check("stream_y0", longint'(y0_o), e.y0);
                    check("stream_y1", longint'(y1_o), e.y1);
                    check("stream_tag", longint'(tag_o), longint'(e.tag));
                    $display("stream result tag=%0h y0=%0d y1=%0d", tag_o, y0_o, y1_o);
                    consumed++;
                end
            end
            if (valid_i && ready_o) begin
                v = make_op(base + idx);
                e.y0 = v.y0; e.y1 = v.y1; e.tag = v.tag;
                sb.push_back(e);
                idx++;
            end
            @(posedge clk_i); #1;
            cyc++;
            ready_i = !(cyc >= stall_start && cyc < stall_start + stall_len);
            if (idx < n_ops) begin
                drive(make_op(base + idx));
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
        end
        check("stream_consumed", consumed, n_ops);
        check("stream_leftover", sb.size(), 0);
        valid_i = 1'b0;
        ready_i = 1'b1;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   max_run;
        int   lat;
        bit   found;
        vec_t v;

        //       mode  sel  a        b        w        tag    y0       y1
        vecs[0] = '{1'b0, 1'b1, 100,     200,     1,       8'h11, 300,     3229};
        vecs[1] = '{1'b1, 1'b1, 3000,    1000,    2,       8'h12, 671,     671};
        vecs[2] = '{1'b0, 1'b0, 0,       1,       8380416, 8'h13, 8380416, 1};
        vecs[3] = '{1'b0, 1'b0, 8380416, 1,       1,       8'h14, 0,       8380415};
        vecs[4] = '{1'b1, 1'b0, 5,       10,      3,       8'h15, 15,      8380402};
        vecs[5] = '{1'b1, 1'b1, 3328,    3328,    3328,    8'h16, 3327,    0};
        vecs[6] = '{1'b0, 1'b1, 0,       3328,    3328,    8'h17, 1,       3328};
        vecs[7] = '{1'b0, 1'b0, 8380416, 8380416, 8380416, 8'h18, 0,       8380415};
        vecs[8] = '{1'b1, 1'b1, 0,       1,       5,       8'h19, 1,       3324};
        vecs[9] = '{1'b0, 1'b0, 123456,  2,       1000,    8'h1a, 125456,  121456};

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; w_i = '0; select_i = 1'b0; mode_i = 1'b0; tag_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_valid_o", longint'(valid_o), 0);
        check("reset_y0", longint'(y0_o), 0);
        check("reset_y1", longint'(y1_o), 0);
        check("reset_tag", longint'(tag_o), 0);
        check("reset_ready_o", longint'(ready_o), 1);
        $display("reset: valid_o=%0d y0=%0d y1=%0d tag=%0h", valid_o, y0_o, y1_o, tag_o);
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++)
            single(vecs[i], $sformatf("vec%0d", i));

        run_stream(16, 0, 1000, 0, max_run);
        check("stream_valid_run", max_run, 16);

        run_stream(16, 100, 6, 5, max_run);

        // Mid-flight reset: three ops accepted, then one reset cycle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            drive(make_op(200 + i));
            valid_i = 1'b1;
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("flush_valid_o", longint'(valid_o), 0);
        $display("flush: valid_o=%0d after reset", valid_o);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            if (valid_o) found = 1'b1;
        end
        check("flush_no_stale", longint'(found), 0);

        v = make_op(301);
        @(posedge clk_i); #1;
        drive(v);
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 0; found = 1'b0;
        while (!found && lat < 10) begin
            @(posedge clk_i); #1;
            lat++;
            if (valid_o) found = 1'b1;
        end
        check("post_reset_latency", lat, 3);
        check("post_reset_y0", longint'(y0_o), v.y0);
        check("post_reset_y1", longint'(y1_o), v.y1);
        check("post_reset_tag", longint'(tag_o), longint'(v.tag));
        $display("post-reset op: y0=%0d y1=%0d tag=%0h", y0_o, y1_o, tag_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
